card_flip_ctrl: RTL and testbench
=================================

CARD_FLIP_CTRL -- requirements
Module: card_flip_ctrl

Interface
REQ-001 Parameter HIDE_DELAY, default 65_000_000, clk cycles a mismatched pair stays revealed before hiding.
REQ-002 Parameter N_CARDS, default 8, number of tiles; fixed 4 columns x 2 rows.
REQ-003 clk  input  1  pixel clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mouse_left  input  1  left mouse button level.
REQ-006 xpos  input  12  mouse x coordinate.
REQ-007 ypos  input  12  mouse y coordinate.
REQ-008 reveal  output  8  per-tile select; 1 = show picture (rgb_in2 path), 0 = show cover.
REQ-009 solved  output  8  per-tile matched flag.
REQ-010 game_done  output  1  high while all tiles are solved.
REQ-011 busy  output  1  high in CHECK and WAIT_HIDE; clicks ignored.

Function
REQ-012 Click = rising edge of mouse_left, detected against a registered copy; held button produces one click only.
REQ-013 Hit test: tile origin X_GRID_0/Y_GRID_0, tiles TILE_SIZE=128 px square; col = (xpos-X_GRID_0)[8:7], row = (ypos-Y_GRID_0)[7]; idx = row*4+col.
REQ-014 Clicks with xpos < X_GRID_0, xpos >= X_GRID_0+512, ypos < Y_GRID_0 or ypos >= Y_GRID_0+256 are ignored.
REQ-015 Clicks on a tile already revealed or solved are ignored.
REQ-016 FSM states IDLE, ONE, CHECK, WAIT_HIDE, DONE.
REQ-017 IDLE: valid click on tile i -> reveal[i]=1 next cycle, first_idx=i, go ONE.
REQ-018 ONE: valid click on tile j -> reveal[j]=1 next cycle, second_idx=j, go CHECK.
REQ-019 CHECK (one cycle): CARD_ID[first_idx]==CARD_ID[second_idx] -> set both solved bits, go IDLE (or DONE if all solved); else load hide counter, go WAIT_HIDE.
REQ-020 WAIT_HIDE: counter counts HIDE_DELAY-1 down to 0; at 0 clear reveal of both tiles, go IDLE; clicks during wait are ignored.
REQ-021 Solved tiles keep reveal=1 permanently until reset.
REQ-022 DONE: game_done=1, all further clicks ignored, exit only by rst.
REQ-023 All outputs registered; click-to-reveal latency exactly 2 cycles from mouse_left rising.

Reset
REQ-024 rst -> state IDLE, reveal=0, solved=0, game_done=0, busy=0, hide counter=0, registered mouse_left=1 (no spurious click if button held through reset).
REQ-025 rst mid-WAIT_HIDE or mid-game aborts immediately; no partial state survives.

Configuration
REQ-026 Macro CARD_FLIP_SCORE_EN defined: adds output moves [7:0], incremented at every CHECK entry, saturating at 255, reset to 0.
REQ-027 Macro undefined: moves port and its counter absent; all other behaviour identical.

Structure
REQ-028 vga_pkg holds X_GRID_0, Y_GRID_0, TILE_SIZE, and CARD_ID table (8 x 3-bit, default {0,1,2,3,0,1,2,3} for idx 0..7).
REQ-029 One sub-module tile_hit_test (combinational xpos/ypos -> idx, hit); FSM and counters in card_flip_ctrl.
REQ-030 reveal[i] drives the select input of the per-tile picture mux.

Verification (HIDE_DELAY=10 in bench)
REQ-031 Click tile 0 then tile 4 -> reveal=8'h11 after second click, solved=8'h11 after CHECK, state IDLE.
REQ-032 Click tile 0 then tile 1 -> reveal=8'h03 for 10 cycles, busy=1, then reveal=8'h00; click on tile 2 during wait ignored.
REQ-033 Hold mouse_left high 100 cycles over tile 3 -> single reveal of bit 3; click on tile 3 again -> no change.
REQ-034 Click at xpos=X_GRID_0+512 or ypos=Y_GRID_0-1 -> no output change.
REQ-035 Solve all four pairs -> solved=8'hFF, game_done=1, moves=4 (SCORE_EN); further clicks ignored.
REQ-036 Assert rst in WAIT_HIDE with button held -> all outputs 0 next cycle; no click registered until button released and re-pressed.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the memory-card game: grid placement, tile size, card pairing
// and the flip controller state encoding.
package vga_pkg;

  localparam int X_GRID_0  = 64;
  localparam int Y_GRID_0  = 112;
  localparam int TILE_SIZE = 128;
  localparam int GRID_COLS = 4;
  localparam int GRID_ROWS = 2;

  // Card identity per tile index; two tiles with the same id form a pair.
  localparam logic [2:0] CARD_ID [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};

  typedef enum logic [2:0] {
    IDLE,
    ONE,
    CHECK,
    WAIT_HIDE,
    DONE
  } flip_state_t;

  function automatic logic cards_match(input logic [2:0] a, input logic [2:0] b);
    return CARD_ID[a] == CARD_ID[b];
  endfunction

endpackage

// File: rtl/card_flip_ctrl_if.sv
// Mouse inputs and tile display outputs of the card flip controller.
// CARD_FLIP_SCORE_EN adds the moves counter output.
interface card_flip_ctrl_if;

  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [7:0]  reveal;
  logic [7:0]  solved;
  logic        game_done;
  logic        busy;
`ifdef CARD_FLIP_SCORE_EN
  logic [7:0]  moves;

  modport master (output mouse_left, xpos, ypos,
                  input  reveal, solved, game_done, busy, moves);
  modport slave  (input  mouse_left, xpos, ypos,
                  output reveal, solved, game_done, busy, moves);
`else
  modport master (output mouse_left, xpos, ypos,
                  input  reveal, solved, game_done, busy);
  modport slave  (input  mouse_left, xpos, ypos,
                  output reveal, solved, game_done, busy);
`endif

endinterface

// File: rtl/card_flip_ctrl_tile_hit_test.sv
// Maps a mouse position to a tile index of the 4x2 grid and flags whether it lies on the grid.
module tile_hit_test
  import vga_pkg::*;
(
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [2:0]  idx,
  output logic        hit
);

  localparam int TILE_SHIFT = $clog2(TILE_SIZE);

  logic [1:0] col;
  logic       row;

  always_comb begin
    col = 2'((xpos - 12'(X_GRID_0)) >> TILE_SHIFT);
    row = 1'((ypos - 12'(Y_GRID_0)) >> TILE_SHIFT);
    idx = {row, col};
    hit = (int'(xpos) >= X_GRID_0) && (int'(xpos) < X_GRID_0 + GRID_COLS * TILE_SIZE) &&
          (int'(ypos) >= Y_GRID_0) && (int'(ypos) < Y_GRID_0 + GRID_ROWS * TILE_SIZE);
  end

endmodule

// File: rtl/card_flip_ctrl.sv
// Memory-game flip controller: turns mouse clicks into tile reveals, pair checks and hide timing.
// Optional macro CARD_FLIP_SCORE_EN adds a saturating moves counter.
module card_flip_ctrl
  import vga_pkg::*;
#(
  parameter int HIDE_DELAY = 65_000_000,
  parameter int N_CARDS    = 8
) (
  input  logic            clk,
  input  logic            rst,
  card_flip_ctrl_if.slave bus
);

  localparam int CNT_W = (HIDE_DELAY > 1) ? $clog2(HIDE_DELAY) : 1;

  flip_state_t        state, state_n;
  logic               btn_q, btn_qq;
  logic [11:0]        x_q, y_q;
  logic [2:0]         hit_idx;
  logic               hit;
  logic               click;
  logic               valid_pick;
  logic [N_CARDS-1:0] reveal_r, reveal_n;
  logic [N_CARDS-1:0] solved_r, solved_n;
  logic [2:0]         first_idx, first_n;
  logic [2:0]         second_idx, second_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               busy_r, busy_n;
  logic               done_r, done_n;
`ifdef CARD_FLIP_SCORE_EN
  logic [7:0]         moves_r, moves_n;
`endif

  tile_hit_test u_hit (
    .xpos (x_q),
    .ypos (y_q),
    .idx  (hit_idx),
    .hit  (hit)
  );

  // Position is registered together with the button so the hit test sees the click-time position.
  assign click      = btn_q & ~btn_qq;
  assign valid_pick = click & hit & ~reveal_r[hit_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q      <= 1'b1;
      btn_qq     <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      state      <= IDLE;
      reveal_r   <= '0;
      solved_r   <= '0;
      first_idx  <= '0;
      second_idx <= '0;
      cnt        <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef CARD_FLIP_SCORE_EN
      moves_r    <= '0;
`endif
    end else begin
      btn_q      <= bus.mouse_left;
      btn_qq     <= btn_q;
      x_q        <= bus.xpos;
      y_q        <= bus.ypos;
      state      <= state_n;
      reveal_r   <= reveal_n;
      solved_r   <= solved_n;
      first_idx  <= first_n;
      second_idx <= second_n;
      cnt        <= cnt_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
`ifdef CARD_FLIP_SCORE_EN
      moves_r    <= moves_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    reveal_n = reveal_r;
    solved_n = solved_r;
    first_n  = first_idx;
    second_n = second_idx;
    cnt_n    = cnt;
`ifdef CARD_FLIP_SCORE_EN
    moves_n  = moves_r;
`endif
    case (state)
      IDLE: begin
        if (valid_pick) begin
          reveal_n[hit_idx] = 1'b1;
          first_n           = hit_idx;
          state_n           = ONE;
        end
      end
      ONE: begin
        if (valid_pick) begin
          reveal_n[hit_idx] = 1'b1;
          second_n          = hit_idx;
          state_n           = CHECK;
`ifdef CARD_FLIP_SCORE_EN
          if (moves_r != 8'hFF) moves_n = moves_r + 8'd1;
`endif
        end
      end
      CHECK: begin
        if (cards_match(first_idx, second_idx)) begin
          solved_n[first_idx]  = 1'b1;
          solved_n[second_idx] = 1'b1;
          state_n              = (&solved_n) ? DONE : IDLE;
        end else begin
          cnt_n   = CNT_W'(HIDE_DELAY - 1);
          state_n = WAIT_HIDE;
        end
      end
      WAIT_HIDE: begin
        if (cnt == '0) begin
          reveal_n[first_idx]  = 1'b0;
          reveal_n[second_idx] = 1'b0;
          state_n              = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n == CHECK) || (state_n == WAIT_HIDE);
    done_n = (state_n == DONE);
  end

  assign bus.reveal    = reveal_r;
  assign bus.solved    = solved_r;
  assign bus.game_done = done_r;
  assign bus.busy      = busy_r;
`ifdef CARD_FLIP_SCORE_EN
  assign bus.moves     = moves_r;
`endif

endmodule

// File: tb/tb_card_flip_ctrl.sv
// Self-checking bench for card_flip_ctrl: directed game scenarios plus randomized mouse traffic
// compared every cycle against an event-level model of the game rules.
module tb_card_flip_ctrl;
  import vga_pkg::*;

  localparam int HIDE = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   check_en = 1'b0;

  card_flip_ctrl_if bus ();

  card_flip_ctrl #(.HIDE_DELAY(HIDE), .N_CARDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: what the player sees, the picks of the current turn and when that turn resolves.
  logic [7:0] m_reveal, m_solved;
  bit         m_done, m_prev_btn, m_pend, m_res_pend, m_res_match;
  int         m_moves, m_pend_x, m_pend_y;
  int         picks[$];
  longint     cyc = 0;
  longint     m_res_edge;

  function automatic int tile_of(input int x, input int y);
    if (x < X_GRID_0 || x >= X_GRID_0 + 512 || y < Y_GRID_0 || y >= Y_GRID_0 + 256) return -1;
    return ((y - Y_GRID_0) / 128) * 4 + (x - X_GRID_0) / 128;
  endfunction

  task automatic modelReset();
    m_reveal = '0; m_solved = '0; m_done = 0; m_moves = 0;
    m_prev_btn = 1; m_pend = 0; m_res_pend = 0;
    picks.delete();
  endtask

  task automatic modelStep();
    int t;
    cyc++;
    if (rst) begin
      modelReset();
      return;
    end
    if (m_res_pend) begin
      if (cyc == m_res_edge) begin
        if (m_res_match) begin
          m_solved[picks[0]] = 1'b1;
          m_solved[picks[1]] = 1'b1;
        end else begin
          m_reveal[picks[0]] = 1'b0;
          m_reveal[picks[1]] = 1'b0;
        end
        picks.delete();
        m_res_pend = 0;
        m_done = (m_solved == 8'hFF);
      end
    end else if (m_pend && !m_done) begin
      t = tile_of(m_pend_x, m_pend_y);
      if (t >= 0 && !m_reveal[t]) begin
        m_reveal[t] = 1'b1;
        picks.push_back(t);
        if (picks.size() == 2) begin
          if (m_moves < 255) m_moves++;
          // Default deck pairs tile t with tile t+4.
          m_res_match = (picks[0] % 4) == (picks[1] % 4);
          m_res_edge  = cyc + 1 + (m_res_match ? 0 : HIDE);
          m_res_pend  = 1;
        end
      end
    end
    m_pend     = bus.mouse_left && !m_prev_btn;
    m_pend_x   = int'(bus.xpos);
    m_pend_y   = int'(bus.ypos);
    m_prev_btn = bus.mouse_left;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %02h expected %02h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("model_reveal", bus.reveal, m_reveal);
        checkOutput("model_solved", bus.solved, m_solved);
        checkOutput("model_done",   {7'd0, bus.game_done}, {7'd0, m_done});
        checkOutput("model_busy",   {7'd0, bus.busy},      {7'd0, m_res_pend});
`ifdef CARD_FLIP_SCORE_EN
        checkOutput("model_moves",  bus.moves, 8'(m_moves));
`endif
      end
    end
  end

  task automatic applyStimulus(input bit btn, input int x, input int y, input int n);
    bus.mouse_left = btn;
    bus.xpos       = 12'(x);
    bus.ypos       = 12'(y);
    repeat (n) @(negedge clk);
  endtask

  task automatic clickAt(input int x, input int y, input int hold);
    applyStimulus(1'b1, x, y, hold);
    applyStimulus(1'b0, x, y, 3);
  endtask

  task automatic clickTile(input int t, input int hold);
    clickAt(X_GRID_0 + (t % 4) * 128 + 40, Y_GRID_0 + (t / 4) * 128 + 40, hold);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b1, 0, 0, 3);
    rst = 1'b0;
    applyStimulus(1'b0, 0, 0, 2);
  endtask

  initial begin
    bus.mouse_left = 1'b1;
    bus.xpos = '0;
    bus.ypos = '0;
    @(negedge clk);
    doReset();
    check_en = 1'b1;
    checkOutput("reset_reveal", bus.reveal, 8'h00);
    checkOutput("reset_solved", bus.solved, 8'h00);
    checkOutput("reset_busy",   {7'd0, bus.busy}, 8'h00);

    // Mismatched pair stays up for the hide delay; a click meanwhile is dropped.
    clickTile(0, 2);
    clickTile(1, 2);
    checkOutput("mismatch_reveal", bus.reveal, 8'h03);
    checkOutput("mismatch_busy",   {7'd0, bus.busy}, 8'h01);
    clickTile(2, 2);
    checkOutput("wait_click_ignored", bus.reveal, 8'h03);
    applyStimulus(1'b0, 0, 0, 4);
    checkOutput("mismatch_hidden", bus.reveal, 8'h00);
    checkOutput("mismatch_idle",   {7'd0, bus.busy}, 8'h00);

    doReset();
    clickTile(0, 2);
    clickTile(4, 2);
    checkOutput("pair04_reveal", bus.reveal, 8'h11);
    checkOutput("pair04_solved", bus.solved, 8'h11);

    // Long hold gives one click; re-clicking the shown tile changes nothing.
    clickTile(3, 100);
    checkOutput("hold_single", bus.reveal, 8'h19);
    clickTile(3, 2);
    checkOutput("reclick_same", bus.reveal, 8'h19);
    checkOutput("reclick_busy", {7'd0, bus.busy}, 8'h00);
    clickTile(7, 2);
    checkOutput("pair37_solved", bus.solved, 8'h99);

    clickAt(X_GRID_0 + 512, Y_GRID_0 + 40, 2);
    clickAt(X_GRID_0 + 40, Y_GRID_0 - 1, 2);
    checkOutput("offgrid_reveal", bus.reveal, 8'h99);

    clickTile(1, 2); clickTile(5, 2);
    clickTile(2, 2); clickTile(6, 2);
    checkOutput("all_solved", bus.solved, 8'hFF);
    checkOutput("game_done",  {7'd0, bus.game_done}, 8'h01);
`ifdef CARD_FLIP_SCORE_EN
    checkOutput("moves_four", bus.moves, 8'd4);
`endif
    clickTile(0, 2);
    checkOutput("done_reveal", bus.reveal, 8'hFF);

    // Reset during the hide wait with the button held down.
    doReset();
    clickTile(0, 2);
    clickTile(1, 2);
    applyStimulus(1'b1, X_GRID_0 + 296, Y_GRID_0 + 40, 2);
    rst = 1'b1;
    applyStimulus(1'b1, X_GRID_0 + 296, Y_GRID_0 + 40, 1);
    rst = 1'b0;
    checkOutput("rst_wait_reveal", bus.reveal, 8'h00);
    checkOutput("rst_wait_busy",   {7'd0, bus.busy}, 8'h00);
    applyStimulus(1'b1, X_GRID_0 + 296, Y_GRID_0 + 40, 5);
    checkOutput("rst_held_noclick", bus.reveal, 8'h00);
    applyStimulus(1'b0, X_GRID_0 + 296, Y_GRID_0 + 40, 2);
    clickTile(2, 2);
    checkOutput("rst_repress", bus.reveal, 8'h04);

    // Random traffic around and across the grid edges, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      applyStimulus($urandom_range(0, 2) == 0,
                    X_GRID_0 - 20 + int'($urandom_range(0, 552)),
                    Y_GRID_0 - 20 + int'($urandom_range(0, 296)), 1);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 0, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
